// File: rtl/counter_ud_prescaled.sv
// Up/down LED counter with a decade-selectable prescaler, synchronous load
// and wrap / saturate / ping-pong count modes. Drives LED, its bit-reversed
// copy Dao, and a one-cycle terminal-count pulse tc.
module counter_ud_prescaled #(
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 3,
  parameter int DIV_BASE = 10,
  parameter int PRE_W    = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic [SEL_W-1:0] SW,
  input  logic             UD,
  input  logic [1:0]       MODE,
  input  logic             LD,
  input  logic [WIDTH-1:0] LD_VAL,
  output logic [WIDTH-1:0] LED,
  output logic [WIDTH-1:0] Dao,
  output logic             tc,
  output logic             dir
);

  localparam int NSPD = 2**SEL_W;

  typedef enum logic [1:0] {
    M_WRAP = 2'b00,
    M_SAT  = 2'b01,
    M_PP   = 2'b10,
    M_WRP2 = 2'b11
  } mode_e;

  // Period-minus-one per speed select, flattened: slot s holds DIV_BASE^(NSPD-1-s) - 1.
  function automatic logic [NSPD*PRE_W-1:0] mk_tab();
    logic [NSPD*PRE_W-1:0] t;
    longint                p;
    t = '0;
    for (int s = 0; s < NSPD; s++) begin
      p = 1;
      for (int k = 0; k < NSPD-1-s; k++) p = p * DIV_BASE;
      t[s*PRE_W +: PRE_W] = PRE_W'(p - 1);
    end
    return t;
  endfunction

  localparam logic [NSPD*PRE_W-1:0] PTAB = mk_tab();

  logic [WIDTH-1:0] led;
  logic [PRE_W-1:0] pre_cnt;
  logic [SEL_W-1:0] sw_q;
  logic             pp_dir;
  logic             tc_q;

  logic [PRE_W-1:0] pm1;
  logic             sw_chg;
  logic [WIDTH-1:0] nxt_led;
  logic             nxt_tc;
  logic             nxt_dir;
  mode_e            mode;

  // sw_q equals SW whenever a step can happen, so the registered copy selects the period
  assign pm1    = PTAB[int'(sw_q)*PRE_W +: PRE_W];
  assign sw_chg = (SW != sw_q);
  assign mode   = mode_e'(MODE);

  // Post-step value, terminal-count flag and bounce direction for the current mode
  always_comb begin
    nxt_led = led;
    nxt_tc  = 1'b0;
    nxt_dir = pp_dir;
    unique case (mode)
      M_SAT: begin
        if (!UD) begin
          if (led == '1) nxt_tc = 1'b1;
          else           nxt_led = led + WIDTH'(1);
        end else begin
          if (led == '0) nxt_tc = 1'b1;
          else           nxt_led = led - WIDTH'(1);
        end
      end
      M_PP: begin
        if (!pp_dir) begin
          if (led == '1) begin
            nxt_led = led - WIDTH'(1);
            nxt_dir = 1'b1;
            nxt_tc  = 1'b1;
          end else nxt_led = led + WIDTH'(1);
        end else begin
          if (led == '0) begin
            nxt_led = WIDTH'(1);
            nxt_dir = 1'b0;
            nxt_tc  = 1'b1;
          end else nxt_led = led - WIDTH'(1);
        end
      end
      default: begin
        if (!UD) begin
          nxt_led = led + WIDTH'(1);
          nxt_tc  = (led == '1);
        end else begin
          nxt_led = led - WIDTH'(1);
          nxt_tc  = (led == '0);
        end
      end
    endcase
  end

  // Counter state: reset > load > speed-change restart > prescaled step > hold
  always_ff @(posedge clk) begin
    sw_q <= SW;
    if (reset) begin
      led     <= '0;
      pre_cnt <= '0;
      pp_dir  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (LD) begin
        led     <= LD_VAL;
        pre_cnt <= '0;
      end else if (sw_chg) begin
        pre_cnt <= '0;
      end else if (En) begin
        if (pre_cnt == pm1) begin
          pre_cnt <= '0;
          led     <= nxt_led;
          tc_q    <= nxt_tc;
          pp_dir  <= nxt_dir;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

  // Bit-reversed LED bank is pure rewiring
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign Dao[i] = led[WIDTH-1-i];
  end

  assign LED = led;
  assign tc  = tc_q;
  assign dir = (mode == M_PP) ? pp_dir : UD;

endmodule

// File: tb/tb_counter_ud_prescaled.sv
// Directed bench for counter_ud_prescaled: hand-written sequences for the
// prescaler timing cases plus a vector table for load/mode/priority cycles.
module tb_counter_ud_prescaled;
  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             reset, En, UD, LD;
  logic [SEL_W-1:0] SW;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] LD_VAL, LED, Dao;
  logic             tc, dir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ud_prescaled #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DIV_BASE(10), .PRE_W(27)) dut (
    .clk(clk), .reset(reset), .En(En), .SW(SW), .UD(UD), .MODE(MODE),
    .LD(LD), .LD_VAL(LD_VAL), .LED(LED), .Dao(Dao), .tc(tc), .dir(dir)
  );

  typedef struct {
    logic             rst;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic [SEL_W-1:0] sw;
    logic             ud;
    logic [1:0]       mode;
    logic [WIDTH-1:0] e_led;
    logic             e_tc;
    logic             e_dir;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  task automatic addv(input logic rst, input logic ld, input logic [WIDTH-1:0] lv,
                      input logic en, input logic [SEL_W-1:0] sw, input logic ud,
                      input logic [1:0] md, input logic [WIDTH-1:0] el,
                      input logic et, input logic ed);
    vec_t v;
    v.rst = rst; v.ld = ld; v.ld_val = lv; v.en = en; v.sw = sw; v.ud = ud;
    v.mode = md; v.e_led = el; v.e_tc = et; v.e_dir = ed;
    vt.push_back(v);
  endtask

  // Count clocks until LED leaves its current value, bounded
  task automatic wait_step(input int bound, output int n);
    logic [WIDTH-1:0] prev;
    prev = LED;
    n = 0;
    while (LED == prev && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;

    // Vector table: {rst, ld, ld_val, en, sw, ud, mode} -> {LED, tc, dir}
    // Saturate down from 2
    addv(0, 1, 8'd2,   0, 7, 1, 2'b01, 8'd2,   0, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b01, 8'd1,   0, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b01, 8'd0,   0, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b01, 8'd0,   1, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b01, 8'd0,   1, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b01, 8'd0,   1, 1);
    // Saturate up at MAX
    addv(0, 1, 8'd254, 0, 7, 0, 2'b01, 8'd254, 0, 0);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b01, 8'd255, 0, 0);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b01, 8'd255, 1, 0);
    // Ping-pong top bounce (UD ignored); load with En high wins over step
    addv(0, 1, 8'd253, 1, 7, 1, 2'b10, 8'd253, 0, 0);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b10, 8'd254, 0, 0);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b10, 8'd255, 0, 0);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b10, 8'd254, 1, 1);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b10, 8'd253, 0, 1);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b10, 8'd252, 0, 1);
    // Ping-pong bottom bounce; load keeps direction register
    addv(0, 1, 8'd1,   1, 7, 0, 2'b10, 8'd1,   0, 1);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b10, 8'd0,   0, 1);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b10, 8'd1,   1, 0);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b10, 8'd2,   0, 0);
    // Priority: load on a would-be wrapping step
    addv(0, 1, 8'd255, 1, 7, 0, 2'b00, 8'd255, 0, 0);
    addv(0, 1, 8'h5A,  1, 7, 0, 2'b00, 8'h5A,  0, 0);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b00, 8'h5B,  0, 0);
    // Wrap down 0 -> MAX
    addv(0, 1, 8'd0,   1, 7, 1, 2'b00, 8'd0,   0, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b00, 8'd255, 1, 1);
    addv(0, 0, 8'd0,   1, 7, 1, 2'b00, 8'd254, 0, 1);
    // MODE 11 behaves as wrap
    addv(0, 1, 8'd255, 1, 7, 0, 2'b11, 8'd255, 0, 0);
    addv(0, 0, 8'd0,   1, 7, 0, 2'b11, 8'd0,   1, 0);
    // Reset beats load and enable; ping-pong dir returns to up
    addv(0, 1, 8'd7,   1, 7, 0, 2'b10, 8'd7,   0, 0);
    addv(1, 1, 8'h5A,  1, 7, 0, 2'b10, 8'd0,   0, 0);

    // Reset state
    reset = 1; En = 0; SW = 7; UD = 0; MODE = 2'b00; LD = 0; LD_VAL = '0;
    tick();
    tick();
    reset = 0;
    chk("rst_led", LED, 0);
    chk("rst_dao", Dao, 0);
    chk("rst_tc",  tc,  0);
    chk("rst_dir", dir, 0);

    // Wrap up at fastest speed
    En = 1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      chk("wrap_led", LED, i % 256);
      chk("wrap_tc",  tc,  (i == 256) ? 1 : 0);
      if (i == 1) chk("dao_01", Dao, 8'h80);
      if (i == 3) chk("dao_03", Dao, 8'hC0);
    end

    // Prescale by 10 and hold
    reset = 1; En = 0; SW = 6;
    tick();
    reset = 0;
    En = 1;
    for (int i = 1; i <= 35; i++) begin
      tick();
      chk("pre_led", LED, i / 10);
      chk("pre_tc",  tc,  0);
    end
    En = 0;
    for (int i = 0; i < 50; i++) tick();
    chk("hold_led", LED, 3);
    En = 1;
    wait_step(40, n);
    chk("resume_gap", n, 5);
    chk("resume_led", LED, 4);
    wait_step(40, n);
    chk("step_gap", n, 10);
    chk("step_led", LED, 5);

    // Vector table
    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; LD = vt[i].ld; LD_VAL = vt[i].ld_val; En = vt[i].en;
      SW = vt[i].sw; UD = vt[i].ud; MODE = vt[i].mode;
      tick();
      chk($sformatf("v%0d_led", i), LED, vt[i].e_led);
      chk($sformatf("v%0d_tc",  i), tc,  vt[i].e_tc);
      chk($sformatf("v%0d_dir", i), dir, vt[i].e_dir);
      chk($sformatf("v%0d_dao", i), Dao, rev(vt[i].e_led));
    end
    reset = 0; LD = 0;

    // Speed switch from slowest to 10-clock period
    reset = 1; En = 0; SW = 0; MODE = 2'b00; UD = 0;
    tick();
    reset = 0;
    En = 1;
    for (int i = 0; i < 1000; i++) tick();
    chk("slow_led", LED, 0);
    SW = 6;
    wait_step(40, n);
    chk("switch_gap", n, 11);
    chk("switch_led", LED, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
